// File: rtl/memoria_principal.sv
// memoria_principal -- main-memory responder behind the memoriaCache memory port.
//
// Services three kinds of request over a req/ready/ack handshake:
//   - plain read  (wren=0, writeBack=0): data_out <= mem[address]
//   - plain write (wren=1, writeBack=0): mem[address] <= data, data_out <= data
//   - write-back  (writeBack=1)        : mem[wb_address] <= wb_data, then a read
//                                        of address (wren and data ignored)
// Each memory access takes LATENCY clock edges. A write-back performs two of them.
//
// Ports:
//   clock       rising-edge clock
//   resetn      synchronous reset, active low
//   req         request strobe, only sampled while ready=1
//   wren        write select for a plain request
//   writeBack   selects the write-back-then-read sequence; overrides wren
//   address     read/write address
//   data        write data for a plain write
//   wb_address  victim line address
//   wb_data     victim line data
//   ready       idle indicator (combinational, state==IDLE)
//   ack         one-cycle completion pulse (registered)
//   data_out    read result, or written word for a plain write; held until next ack
//
// Optional build macro MEMORIA_ACCESS_COUNT_EN adds read_count[7:0] and
// write_count[7:0], saturating counters of memory accesses.

module memoria_principal #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 3,
  parameter int LATENCY = 2   // legal range 1..15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              wren,
  input  logic              writeBack,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] data_out
`ifdef MEMORIA_ACCESS_COUNT_EN
  ,
  output logic [7:0]        read_count,
  output logic [7:0]        write_count
`endif
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_WAIT,
    S_WR_WAIT,
    S_RD_WAIT,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          counter_q, counter_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;

  // Request fields captured at the accept edge; the live inputs are ignored
  // afterwards so the cache may change them freely while we are busy.
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;

  // The memory is re-initialised by reset, so it is built from registers
  // rather than a RAM primitive; the read is still captured into data_out_q.
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    ack_d      = 1'b0;
    data_out_d = data_out_q;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = data_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          counter_d = CNT_RELOAD;
          if (writeBack)   state_d = S_WB_WAIT;
          else if (wren)   state_d = S_WR_WAIT;
          else             state_d = S_RD_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (counter_q == 4'd0) begin
          mem_we    = 1'b1;
          mem_waddr = wb_addr_q;
          mem_wdata = wb_data_q;
          counter_d = CNT_RELOAD;   // second access: the fill read
          state_d   = S_RD_WAIT;
        end else begin
          counter_d = counter_q - 4'd1;
        end
      end
      S_WR_WAIT: begin
        if (counter_q == 4'd0) begin
          mem_we     = 1'b1;
          data_out_d = data_q;
          ack_d      = 1'b1;
          state_d    = S_ACK;
        end else begin
          counter_d = counter_q - 4'd1;
        end
      end
      S_RD_WAIT: begin
        if (counter_q == 4'd0) begin
          // Any victim write of this transaction landed on an earlier edge,
          // so a matching address already reads back wb_data here.
          data_out_d = mem_q[addr_q];
          ack_d      = 1'b1;
          state_d    = S_ACK;
        end else begin
          counter_d = counter_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      counter_q  <= 4'd0;
      ack_q      <= 1'b0;
      data_out_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);     // i mod 2^DATA_W
      end
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      ack_q      <= ack_d;
      data_out_q <= data_out_d;
      if (accept) begin
        addr_q    <= address;
        data_q    <= data;
        wb_addr_q <= wb_address;
        wb_data_q <= wb_data;
      end
      if (mem_we) begin
        mem_q[mem_waddr] <= mem_wdata;
      end
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign ack      = ack_q;
  assign data_out = data_out_q;

`ifdef MEMORIA_ACCESS_COUNT_EN
  logic [7:0] read_count_q;
  logic [7:0] write_count_q;
  logic       rd_event;

  assign rd_event = (state_q == S_RD_WAIT) && (counter_q == 4'd0);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      read_count_q  <= 8'd0;
      write_count_q <= 8'd0;
    end else begin
      if (rd_event && (read_count_q != 8'hFF)) begin
        read_count_q <= read_count_q + 8'd1;
      end
      if (mem_we && (write_count_q != 8'hFF)) begin
        write_count_q <= write_count_q + 8'd1;
      end
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_memoria_principal.sv
// Directed testbench for memoria_principal (LATENCY=2, ADDR_W=5, DATA_W=3).
// Memory starts as mem[i] = i mod 8 after reset.

module tb_memoria_principal;

  localparam int LAT = 2;

  logic       clock;
  logic       resetn;
  logic       req;
  logic       wren;
  logic       writeBack;
  logic [4:0] address;
  logic [2:0] data;
  logic [4:0] wb_address;
  logic [2:0] wb_data;
  logic       ready;
  logic       ack;
  logic [2:0] data_out;
`ifdef MEMORIA_ACCESS_COUNT_EN
  logic [7:0] read_count;
  logic [7:0] write_count;
`endif

  int total = 0;
  int bad   = 0;

  memoria_principal #(
    .ADDR_W (5),
    .DATA_W (3),
    .LATENCY(LAT)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .wren      (wren),
    .writeBack (writeBack),
    .address   (address),
    .data      (data),
    .wb_address(wb_address),
    .wb_data   (wb_data),
    .ready     (ready),
    .ack       (ack),
    .data_out  (data_out)
`ifdef MEMORIA_ACCESS_COUNT_EN
    ,
    .read_count (read_count),
    .write_count(write_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ack and ready must never overlap.
  always @(negedge clock) begin
    if (resetn && ack && ready) check("ack_and_ready", 32'(ack && ready), 0);
  end

  // One full transaction: drive at negedge, accept at the next edge, then
  // scramble the live inputs to prove they were latched.
  task automatic run_txn(input string tag, input logic wr, input logic wb,
                         input logic [4:0] a, input logic [2:0] d,
                         input logic [4:0] wa, input logic [2:0] wd,
                         input int exp_lat, input logic [2:0] exp_d);
    int lat;
    lat = 0;
    @(negedge clock);
    req = 1'b1; wren = wr; writeBack = wb;
    address = a; data = d; wb_address = wa; wb_data = wd;
    @(posedge clock);  // t0
    #1;
    req = 1'b0;
    address = a ^ 5'h1F; data = ~d; wb_address = wa ^ 5'h1F; wb_data = ~wd;
    check({tag, "_busy"}, 32'(ready), 0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (ack) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, 32'(data_out), 32'(exp_d));
    check({tag, "_rdy_in_ack"}, 32'(ready), 0);
    @(posedge clock);
    #1;
    check({tag, "_ack_drop"}, 32'(ack), 0);
    check({tag, "_rdy_back"}, 32'(ready), 1);
    check({tag, "_held"}, 32'(data_out), 32'(exp_d));
    $display("txn %s: wr=%0d wb=%0d addr=%0d lat=%0d data_out=%0d", tag, wr, wb, a, lat, data_out);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [2:0] seen;
    resetn = 1'b0; req = 1'b0; wren = 1'b0; writeBack = 1'b0;
    address = '0; data = '0; wb_address = '0; wb_data = '0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    check("rst_ready", 32'(ready), 1);
    check("rst_ack", 32'(ack), 0);
    check("rst_data", 32'(data_out), 0);
`ifdef MEMORIA_ACCESS_COUNT_EN
    check("rst_rcnt", 32'(read_count), 0);
    check("rst_wcnt", 32'(write_count), 0);
`endif

    // 1: plain read of initial contents
    run_txn("t1_rd5", 0, 0, 5'b00101, 3'd0, 5'd0, 3'd0, LAT, 3'd5);
    // 2: write, then read it back
    run_txn("t2_wr1", 1, 0, 5'b00001, 3'b101, 5'd0, 3'd0, LAT, 3'd5);
    run_txn("t2_rd1", 0, 0, 5'b00001, 3'd0, 5'd0, 3'd0, LAT, 3'd5);
    // 3: write-back then fill read of a different line
    run_txn("t3_wb", 0, 1, 5'b01001, 3'd0, 5'b00001, 3'b100, 2*LAT, 3'd1);
    run_txn("t3_rd1", 0, 0, 5'b00001, 3'd0, 5'd0, 3'd0, LAT, 3'd4);
    // 4: write-back to the same address (wren also set, data ignored)
    run_txn("t4_wbsame", 1, 1, 5'b00101, 3'b110, 5'b00101, 3'b011, 2*LAT, 3'd3);

    // 5: req while busy must be ignored
    @(negedge clock);
    req = 1'b1; wren = 1'b0; writeBack = 1'b0; address = 5'b10000;
    @(posedge clock);  // t0
    #1;
    address = 5'b00011; data = 3'b110; wren = 1'b1; req = 1'b1;
    @(posedge clock);  // t0+1, busy
    #1;
    req = 1'b0;
    acks = 0; seen = '0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clock);
      #1;
      if (ack) begin
        acks++;
        seen = data_out;
      end
    end
    check("t5_acks", acks, 1);
    check("t5_data", 32'(seen), 0);
    $display("txn t5_busyreq: acks=%0d data_out=%0d", acks, seen);
    run_txn("t5_rd3", 0, 0, 5'b00011, 3'd0, 5'd0, 3'd0, LAT, 3'd3);

    // 6: reset in the middle of a write
    @(negedge clock);
    req = 1'b1; wren = 1'b1; writeBack = 1'b0; address = 5'b00001; data = 3'b111;
    @(posedge clock);  // t0
    #1;
    req = 1'b0; resetn = 1'b0;
    @(posedge clock);  // t0+1, reset sampled
    #1;
    resetn = 1'b1;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clock);
      #1;
      if (ack) acks++;
    end
    check("t6_noack", acks, 0);
    check("t6_ready", 32'(ready), 1);
    $display("txn t6_rstmid: acks=%0d ready=%0d", acks, ready);
`ifdef MEMORIA_ACCESS_COUNT_EN
    check("t6_rcnt0", 32'(read_count), 0);
    check("t6_wcnt0", 32'(write_count), 0);
`endif
    run_txn("t6_rd1", 0, 0, 5'b00001, 3'd0, 5'd0, 3'd0, LAT, 3'd1);
`ifdef MEMORIA_ACCESS_COUNT_EN
    check("t6_rcnt1", 32'(read_count), 1);
    check("t6_wcnt1", 32'(write_count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memoria_principal.md
Name: memoria_principal

Overview:
- Main-memory responder on the memory side of memoriaCache. Services the cache's fill reads, write-through writes and dirty-line write-backs over a req/ready/ack handshake with configurable access latency.
- Holds 2^ADDR_W words of DATA_W bits.
- A write-back request chains two accesses: it writes the victim line, then reads the fill line.

Parameters:
ADDR_W, 5, address width (3-bit tag + 2-bit index as used by the cache)
DATA_W, 3, word width
LATENCY, 2, clock edges per memory access; legal range 1..15

Ports:
clock  input  1  single clock, rising edge
resetn  input  1  synchronous reset, active-low
req  input  1  request strobe; sampled only when ready=1
wren  input  1  1 = write data to address; 0 = read address
writeBack  input  1  1 = write wb_data to wb_address, then read address; overrides wren
address  input  ADDR_W  read or write address
data  input  DATA_W  write data (used when wren=1, writeBack=0)
wb_address  input  ADDR_W  victim line address
wb_data  input  DATA_W  victim line data
ready  output  1  idle, request can be accepted; combinational, equals (state==IDLE)
ack  output  1  one-cycle completion pulse, registered
data_out  output  DATA_W  read result, or written word for a plain write; registered, held until the next ack

Behaviour:
- Reset: synchronous, active-low, sampled on clock rising edge.
  - state<=IDLE, counter<=0, ack<=0, data_out<=0.
  - mem[i] <= i mod 2^DATA_W for all i.
  - ready=1 from the first edge with resetn=1.
- Accept edge t0: req=1 and state==IDLE.
  - Latch wren, writeBack, address, data, wb_address, wb_data; later input changes are ignored.
  - counter <= LATENCY-1.
- States:
  - IDLE: go to WB_WAIT if writeBack; else WR_WAIT if wren; else RD_WAIT.
  - WB_WAIT: decrement counter each edge. At counter==0: mem[wb_address]<=wb_data, counter<=LATENCY-1, go to RD_WAIT.
  - WR_WAIT: at counter==0: mem[address]<=data, data_out<=data, ack<=1, go to ACK.
  - RD_WAIT: at counter==0: data_out<=mem[address] (value after any write-back this transaction), ack<=1, go to ACK.
  - ACK: ack<=0, go to IDLE.
- Timing:
  - Read or write: ack high for the cycle after edge t0+LATENCY.
  - Write-back: ack high for the cycle after edge t0+2*LATENCY.
  - ready=1 again after the ack cycle. A new req in that first ready cycle is accepted.
- Boundary cases:
  - req while ready=0: ignored, not queued.
  - wren=1 with writeBack=1: treated as a write-back; data is ignored.
  - wb_address==address: read returns wb_data.
  - Reset mid-transaction: abort, no ack, memory re-initialised.
  - ack and ready are never high in the same cycle.
  - Addresses cover the full 2^ADDR_W range; no wrap is needed.
- Counter width: 4 bits. counter is unused in IDLE and ACK.

Optional Feature:
- Macro: MEMORIA_ACCESS_COUNT_EN.
- When defined, adds outputs read_count[7:0] and write_count[7:0]:
  - Each is 0 at reset.
  - Incremented at the edge the corresponding memory access occurs; a write-back increments both, at its two access edges.
  - Saturate at 255.
- When undefined, neither port nor logic exists.

Test Plan:
1. Reset, then read address=5'b00101 (LATENCY=2) -> ack in cycle after t0+2, data_out=5; ready=0 from t0+1 through the ack cycle.
2. Write address=5'b00001, data=3'b101 -> ack at t0+2, data_out=5; then read 5'b00001 -> data_out=5.
3. writeBack=1, wb_address=5'b00001, wb_data=3'b100, address=5'b01001 -> ack in cycle after t0+4, data_out=1; then read 5'b00001 -> 4.
4. writeBack=1, wb_address=address=5'b00101, wb_data=3'b011 -> data_out=3 at t0+4 ack.
5. During a read of 5'b10000, toggle address and assert req with wren=1 at t0+1 -> single ack, data_out=0, mem unchanged, no second ack.
6. Start write 5'b00001 <= 3'b111, resetn=0 at t0+1 -> no ack, ready=1 after reset, read 5'b00001 -> 1. With MEMORIA_ACCESS_COUNT_EN, counters read 0 after reset and 1/0 after this read.
